// File: rtl/tim_apb_cfg_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tim_apb_cfg_seq_if : APB bus bundle between config sequencer and timer      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface tim_apb_cfg_seq_if;
  logic        timx_psel;
  logic        timx_penable;
  logic        timx_pwrite;
  logic [15:0] timx_paddr;
  logic [31:0] timx_pwdata;
  logic [31:0] timx_prdata;
  logic        timx_pready;

  modport master (
    output timx_psel, timx_penable, timx_pwrite, timx_paddr, timx_pwdata,
    input  timx_prdata, timx_pready
  );

  modport slave (
    input  timx_psel, timx_penable, timx_pwrite, timx_paddr, timx_pwdata,
    output timx_prdata, timx_pready
  );
endinterface
`default_nettype wire

// File: rtl/tim_apb_cfg_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tim_apb_cfg_seq : APB master writing an (addr,data,mask) table to the timer |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tim_apb_cfg_seq #(
  parameter int IDX_W   = 4,
  parameter int VERIFY  = 0,
  parameter int TIMEOUT = 16
) (
  input  logic              apb_clk,
  input  logic              apb_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  num_entries,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [15:0]       tbl_addr,
  input  logic [31:0]       tbl_data,
  input  logic [31:0]       tbl_mask,
  tim_apb_cfg_seq_if.master apb,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [IDX_W-1:0]  err_idx
);

  localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WSETUP = 3'd2,
    S_WACC   = 3'd3,
    S_RSETUP = 3'd4,
    S_RACC   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t             r_state;
  state_t             w_state_n;
  logic [IDX_W-1:0]   r_tbl_idx;
  logic [IDX_W-1:0]   w_idx_n;
  logic [IDX_W-1:0]   r_num;
  logic [15:0]        r_addr;
  logic [31:0]        r_data;
  logic [31:0]        r_mask;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_abort;
  logic               r_err;
  logic [1:0]         r_err_code;
  logic [IDX_W-1:0]   r_err_idx;

  logic               w_accept;
  logic               w_set_err;
  logic [1:0]         w_code_n;
  logic               w_xfer_ok;
  logic               w_in_acc;
  logic               w_to;
  logic               w_mismatch;
  logic               w_last;
  logic               w_abort_any;
  logic [IDX_W-1:0]   w_idx_inc;

  assign w_in_acc    = (r_state == S_WACC) || (r_state == S_RACC);
  assign w_to        = (r_cnt == c_CNT_LAST);
  assign w_mismatch  = |((apb.timx_prdata ^ r_data) & r_mask);
  assign w_last      = (r_tbl_idx == (r_num - 1'b1));
  assign w_abort_any = r_abort | abort;
  assign w_idx_inc   = r_tbl_idx + 1'b1;

  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_tbl_idx;
    w_accept  = 1'b0;
    w_set_err = 1'b0;
    w_code_n  = 2'd0;
    w_xfer_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept  = 1'b1;
          w_idx_n   = '0;
          w_state_n = (num_entries == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD:   w_state_n = S_WSETUP;
      S_WSETUP: w_state_n = S_WACC;
      S_WACC: begin
        if (apb.timx_pready) begin
          if (VERIFY != 0) w_state_n = S_RSETUP;
          else             w_xfer_ok = 1'b1;
        end else if (w_to) begin
          w_set_err = 1'b1;
          w_code_n  = 2'd1;
          w_state_n = S_ERR;
        end
      end
      S_RSETUP: w_state_n = S_RACC;
      S_RACC: begin
        if (apb.timx_pready) begin
          if (w_mismatch) begin
            w_set_err = 1'b1;
            w_code_n  = 2'd2;
            w_state_n = S_ERR;
          end else begin
            w_xfer_ok = 1'b1;
          end
        end else if (w_to) begin
          w_set_err = 1'b1;
          w_code_n  = 2'd1;
          w_state_n = S_ERR;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // A pending abort stops us before the next entry, even after the last one.
    if (w_xfer_ok) begin
      if (w_abort_any) begin
        w_idx_n   = w_idx_inc;
        w_set_err = 1'b1;
        w_code_n  = 2'd3;
        w_state_n = S_ERR;
      end else if (w_last) begin
        w_state_n = S_DONE;
      end else begin
        w_idx_n   = w_idx_inc;
        w_state_n = S_LOAD;
      end
    end
  end

  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      r_tbl_idx  <= '0;
      r_num      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_cnt      <= '0;
      r_abort    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_err_idx  <= '0;
    end else begin
      r_tbl_idx <= w_idx_n;
      if (w_accept) begin
        r_num      <= num_entries;
        r_err      <= 1'b0;
        r_err_code <= 2'd0;
        r_err_idx  <= '0;
      end
      if (w_set_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_code_n;
        r_err_idx  <= w_idx_n;
      end
      if (r_state == S_LOAD) begin
        r_addr <= tbl_addr;
        r_data <= tbl_data;
        r_mask <= tbl_mask;
      end
      if ((r_state == S_WSETUP) || (r_state == S_RSETUP)) r_cnt <= '0;
      else if (w_in_acc && !apb.timx_pready)                r_cnt <= r_cnt + 1'b1;
      if ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR)) r_abort <= 1'b0;
      else if (abort)                                                        r_abort <= 1'b1;
    end
  end

  assign apb.timx_psel    = (r_state == S_WSETUP) || (r_state == S_WACC) ||
                            (r_state == S_RSETUP) || (r_state == S_RACC);
  assign apb.timx_penable = w_in_acc;
  assign apb.timx_pwrite  = (r_state == S_WSETUP) || (r_state == S_WACC);
  assign apb.timx_paddr   = r_addr;
  assign apb.timx_pwdata  = r_data;

  assign tbl_idx  = r_tbl_idx;
  assign busy     = (r_state == S_LOAD) || apb.timx_psel;
  assign done     = (r_state == S_DONE);
  assign err      = r_err;
  assign err_code = r_err_code;
  assign err_idx  = r_err_idx;

endmodule
`default_nettype wire
